led_blink_ctrl: RTL

//  Parametrised multi-channel LED driver; successor to the fixed 1 s top-level blink counter.
//  A shared prescaler derives a tick from the SoC clock; each channel runs its own
//  OFF/ON/BLINK/ONESHOT mode with a programmable half-period counted in ticks.

---
 rtl/led_ctrl_pkg.sv | 19 +
 rtl/led_channel.sv | 82 ++++++++
 rtl/led_blink_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the multi-channel LED blink controller: mode encodings,
// prescaler divide computation and the PWM counter width.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } led_mode_e;

  localparam int PWM_W = 8;

  // Number of clock cycles per prescaler tick; callers must keep the result >= 2.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds mode, half-period, tick counter and the registered LED state.
// A configuration write always takes priority over a tick arriving in the same cycle.
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [1:0]          wr_mode,
  input  logic [PERIOD_W-1:0] wr_half_per,
  input  logic                tick,
  output logic                led,
  output logic                busy
);

  led_mode_e           mode_q, mode_d;
  logic [PERIOD_W-1:0] half_per_q, half_per_d;
  logic [PERIOD_W-1:0] count_q, count_d;
  logic                led_q, led_d;
  logic [PERIOD_W-1:0] last_count;
  logic                at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_OFF;
      half_per_q <= '0;
      count_q    <= '0;
      led_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      half_per_q <= half_per_d;
      count_q    <= count_d;
      led_q      <= led_d;
    end
  end

  // A half-period of zero behaves as one tick, so the terminal count is then zero too.
  assign last_count = (half_per_q == '0) ? '0 : half_per_q - PERIOD_W'(1);
  assign at_last    = (count_q == last_count);

  always_comb begin
    mode_d     = mode_q;
    half_per_d = half_per_q;
    count_d    = count_q;
    led_d      = led_q;
    if (wr_en) begin
      mode_d     = led_mode_e'(wr_mode);
      half_per_d = wr_half_per;
      count_d    = '0;
      led_d      = (led_mode_e'(wr_mode) != MODE_OFF);
    end else if (tick) begin
      unique case (mode_q)
        MODE_BLINK: begin
          if (at_last) begin
            led_d   = ~led_q;
            count_d = '0;
          end else begin
            count_d = count_q + PERIOD_W'(1);
          end
        end
        MODE_ONESHOT: begin
          if (at_last) begin
            led_d   = 1'b0;
            mode_d  = MODE_OFF;
            count_d = '0;
          end else begin
            count_d = count_q + PERIOD_W'(1);
          end
        end
        default: count_d = '0;
      endcase
    end
  end

  always_comb begin
    led  = led_q;
    busy = (mode_q == MODE_ONESHOT);
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver: shared tick prescaler, single-port config write decode and
// NUM_CH led_channel instances. Optional PWM dimming is enabled by defining LED_PWM_EN.
module led_blink_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_half_per,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]    cfg_duty,
`endif
  output logic                tick_o,
  output logic [NUM_CH-1:0]   led_o,
  output logic [NUM_CH-1:0]   busy_o
);

  localparam int DIV     = calc_div(CLK_HZ, TICK_HZ);
  localparam int PRESC_W = $clog2(DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  logic [PRESC_W-1:0] presc_q;
  logic [NUM_CH-1:0]  wr_sel;
  logic [NUM_CH-1:0]  raw_led;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  assign tick_o = (presc_q == PRESC_LAST);

  // Out-of-range channel numbers simply match no channel and are dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        wr_sel[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_channel #(
      .PERIOD_W (PERIOD_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_sel[g]),
      .wr_mode     (cfg_mode),
      .wr_half_per (cfg_half_per),
      .tick        (tick_o),
      .led         (raw_led[g]),
      .busy        (busy_o[g])
    );
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0]  duty_q [NUM_CH];
  logic [PWM_W-1:0]  pwm_cnt;
  logic [NUM_CH-1:0] led_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i] <= '1;
      end
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_sel[i]) begin
          duty_q[i] <= cfg_duty;
        end
      end
    end
  end

  // Dimmed output is re-registered, adding one cycle after the raw channel state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        led_q[i] <= raw_led[i] & (pwm_cnt < duty_q[i]);
      end
    end
  end

  assign led_o = led_q;
`else
  assign led_o = raw_led;
`endif

endmodule
